// File: rtl/bcd_timer_core.sv
// BCD stopwatch/countdown core: IDLE/RUN/PAUSE/DONE, one count step every TICK_DIV clocks.
// Edge inputs act one cycle after they rise; no backpressure. Optional lap capture under LAP_CAPTURE_EN.
module bcd_timer_core #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic [1:0]            mode,
  input  logic [4*DIGITS-1:0]   preset,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done
`ifdef LAP_CAPTURE_EN
  ,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   lap_value,
  output logic                  lap_valid
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    count_q, count_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            dir_q, dir_d;
  logic            done_q, done_d;
  logic            ss_q, clr_q;
  logic            ss_edge, clr_edge, tick;
  logic [W-1:0]    start_val, step_val;

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Terminal value depends only on direction: up stops at all-9s, down stops at zero.
  function automatic logic [W-1:0] term_val(input logic down);
    return down ? '0 : NINES;
  endfunction

  assign ss_edge   = start_stop & ~ss_q;
  assign clr_edge  = clear & ~clr_q;
  assign tick      = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));
  assign start_val = mode[0] ? bcd_clamp(preset) : (mode[1] ? NINES : '0);
  assign step_val  = dir_q ? bcd_dec(count_q) : bcd_inc(count_q);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (clr_edge) begin
      state_d = IDLE;
      count_d = start_val;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          count_d = start_val;
          if (ss_edge) begin
            dir_d   = mode[1];
            presc_d = '0;
            if (start_val == term_val(mode[1])) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          // A pause edge still lets this last RUN cycle advance the prescaler.
          if (ss_edge) state_d = PAUSE;
          if (tick) begin
            presc_d = '0;
            count_d = step_val;
            if (step_val == term_val(dir_q)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (ss_edge) state_d = RUN;
        end
        DONE: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      presc_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      ss_q    <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      ss_q    <= start_stop;
      clr_q   <= clear;
    end
  end

  assign count   = count_q;
  assign running = (state_q == RUN);
  assign done    = done_q;

`ifdef LAP_CAPTURE_EN
  logic         lap_q;
  logic         lap_edge;
  logic [W-1:0] lap_value_q, lap_value_d;
  logic         lap_valid_q, lap_valid_d;

  assign lap_edge = lap & ~lap_q;

  always_comb begin
    lap_value_d = lap_value_q;
    lap_valid_d = lap_valid_q;
    if (clr_edge) begin
      lap_valid_d = 1'b0;
    end else if (lap_edge) begin
      if (state_q == RUN && !lap_valid_q) begin
        lap_value_d = count_q;
        lap_valid_d = 1'b1;
      end else if ((state_q == RUN || state_q == PAUSE) && lap_valid_q) begin
        lap_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_q       <= 1'b0;
      lap_value_q <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_q       <= lap;
      lap_value_q <= lap_value_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_value = lap_value_q;
  assign lap_valid = lap_valid_q;
`endif

endmodule

// File: tb/tb_bcd_timer_core.sv
// Scoreboard bench for bcd_timer_core (DIGITS=4, TICK_DIV=4): expected samples are queued
// with the cycle they are due and compared on the falling edge of that cycle.
module tb_bcd_timer_core;

  logic        clk;
  logic        reset;
  logic        start_stop;
  logic        clear;
  logic [1:0]  mode;
  logic [15:0] preset;
  logic [15:0] count;
  logic        running;
  logic        done;
`ifdef LAP_CAPTURE_EN
  logic        lap;
  logic [15:0] lap_value;
  logic        lap_valid;
`endif

  bcd_timer_core #(.DIGITS(4), .TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .clear      (clear),
    .mode       (mode),
    .preset     (preset),
    .count      (count),
    .running    (running),
    .done       (done)
`ifdef LAP_CAPTURE_EN
    ,
    .lap        (lap),
    .lap_value  (lap_value),
    .lap_valid  (lap_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
    logic        run;
    logic        dn;
    bit          is_lap;
    logic [15:0] lv;
    logic        lvld;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_at(input int at, input string tag, input logic [15:0] c,
                           input logic r, input logic d);
    exp_t e;
    e.cyc = at; e.cnt = c; e.run = r; e.dn = d;
    e.is_lap = 1'b0; e.lv = '0; e.lvld = 1'b0;
    sb.push_back(e);
    sb_tag.push_back(tag);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        if (sb[i].is_lap) begin
`ifdef LAP_CAPTURE_EN
          chk({sb_tag[i], ".lap_value"}, 32'(lap_value), 32'(sb[i].lv));
          chk({sb_tag[i], ".lap_valid"}, 32'(lap_valid), 32'(sb[i].lvld));
`endif
        end else begin
          chk({sb_tag[i], ".count"},   32'(count),   32'(sb[i].cnt));
          chk({sb_tag[i], ".running"}, 32'(running), 32'(sb[i].run));
          chk({sb_tag[i], ".done"},    32'(done),    32'(sb[i].dn));
        end
        sb.delete(i);
        sb_tag.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  int s;
  int c;

  initial begin
    reset = 1'b0; start_stop = 1'b0; clear = 1'b0; mode = 2'b10; preset = 16'h0000;
`ifdef LAP_CAPTURE_EN
    lap = 1'b0;
`endif
    #2;
    chk("reset.count",   32'(count),   32'h0);
    chk("reset.running", 32'(running), 32'h0);
    chk("reset.done",    32'(done),    32'h0);
`ifdef LAP_CAPTURE_EN
    chk("reset.lap_value", 32'(lap_value), 32'h0);
    chk("reset.lap_valid", 32'(lap_valid), 32'h0);
`endif
    step(2);

    // First edge after release loads the mode start value (mode 10 -> all 9s).
    reset = 1'b1;
    s = cyc;
    expect_at(s + 1, "release_load", 16'h9999, 1'b0, 1'b0);
    step(3);

    // Up from zero; mode change mid-run must not alter direction.
    mode = 2'b00;
    step(1);
    s = cyc;
    expect_at(s + 1,  "up_go",  16'h0000, 1'b1, 1'b0);
    expect_at(s + 5,  "up_t1",  16'h0001, 1'b1, 1'b0);
    expect_at(s + 40, "up_t9",  16'h0009, 1'b1, 1'b0);
    expect_at(s + 41, "up_t10", 16'h0010, 1'b1, 1'b0);
    pulse_ss();
    mode = 2'b11;
    step(45);

    // Preset clamp, then multi-digit carry.
    mode = 2'b01; preset = 16'hF0C3;
    c = cyc;
    expect_at(c + 1, "clamp", 16'h9093, 1'b0, 1'b0);
    pulse_clr();
    step(2);
    preset = 16'h0199;
    step(1);
    s = cyc;
    expect_at(s + 1, "carry_go", 16'h0199, 1'b1, 1'b0);
    expect_at(s + 5, "carry",    16'h0200, 1'b1, 1'b0);
    pulse_ss();
    step(6);

    // Countdown to zero, done pulse, start edges ignored in DONE.
    mode = 2'b11; preset = 16'h0002;
    c = cyc;
    expect_at(c + 1, "dn_clr", 16'h0002, 1'b0, 1'b0);
    pulse_clr();
    step(1);
    s = cyc;
    expect_at(s + 1,  "dn_go",    16'h0002, 1'b1, 1'b0);
    expect_at(s + 5,  "dn_t1",    16'h0001, 1'b1, 1'b0);
    expect_at(s + 9,  "dn_done",  16'h0000, 1'b0, 1'b1);
    expect_at(s + 10, "dn_after", 16'h0000, 1'b0, 1'b0);
    pulse_ss();
    step(10);
    s = cyc;
    expect_at(s + 1, "done_ign1", 16'h0000, 1'b0, 1'b0);
    expect_at(s + 5, "done_ign5", 16'h0000, 1'b0, 1'b0);
    pulse_ss();
    step(6);

    // Start value already terminal: straight to DONE.
    preset = 16'h0000;
    c = cyc;
    expect_at(c + 1, "imm_clr", 16'h0000, 1'b0, 1'b0);
    pulse_clr();
    step(1);
    s = cyc;
    expect_at(s + 1, "imm_done", 16'h0000, 1'b0, 1'b1);
    expect_at(s + 2, "imm_one",  16'h0000, 1'b0, 1'b0);
    pulse_ss();
    step(3);

    // Borrow across digits, and down from all 9s.
    preset = 16'h1000;
    c = cyc;
    expect_at(c + 1, "brw_clr", 16'h1000, 1'b0, 1'b0);
    pulse_clr();
    step(1);
    s = cyc;
    expect_at(s + 1, "brw_go", 16'h1000, 1'b1, 1'b0);
    expect_at(s + 5, "borrow", 16'h0999, 1'b1, 1'b0);
    pulse_ss();
    step(6);
    mode = 2'b10;
    c = cyc;
    expect_at(c + 1, "nines_clr", 16'h9999, 1'b0, 1'b0);
    pulse_clr();
    step(1);
    s = cyc;
    expect_at(s + 5, "nines_t1", 16'h9998, 1'b1, 1'b0);
    pulse_ss();
    step(6);

    // Pause/resume: prescaler held, tick two cycles after resume.
    mode = 2'b00;
    c = cyc;
    expect_at(c + 1, "pz_clr", 16'h0000, 1'b0, 1'b0);
    pulse_clr();
    step(1);
    s = cyc;
    expect_at(s + 1,  "pz_go",     16'h0000, 1'b1, 1'b0);
    expect_at(s + 5,  "pz_t1",     16'h0001, 1'b1, 1'b0);
    expect_at(s + 7,  "pz_paused", 16'h0001, 1'b0, 1'b0);
    expect_at(s + 17, "pz_mid",    16'h0001, 1'b0, 1'b0);
    expect_at(s + 26, "pz_end",    16'h0001, 1'b0, 1'b0);
    expect_at(s + 27, "pz_resume", 16'h0001, 1'b1, 1'b0);
    expect_at(s + 28, "pz_r1",     16'h0001, 1'b1, 1'b0);
    expect_at(s + 29, "pz_tick",   16'h0002, 1'b1, 1'b0);
    pulse_ss();
    step(5);
    pulse_ss();
    step(19);
    pulse_ss();
    step(4);

    // Clear and start_stop together in RUN: clear wins, reload with current mode.
    c = cyc;
    mode = 2'b01; preset = 16'h0042;
    clear = 1'b1; start_stop = 1'b1;
    expect_at(c + 1, "clr_win",  16'h0042, 1'b0, 1'b0);
    expect_at(c + 3, "clr_hold", 16'h0042, 1'b0, 1'b0);
    step(1);
    clear = 1'b0; start_stop = 1'b0;
    step(3);

    // Asynchronous reset mid-run: immediate clear, no done pulse afterwards.
    s = cyc;
    expect_at(s + 1, "ar_go", 16'h0042, 1'b1, 1'b0);
    expect_at(s + 5, "ar_t1", 16'h0043, 1'b1, 1'b0);
    pulse_ss();
    step(5);
    reset = 1'b0;
    #1;
    chk("arst.count",   32'(count),   32'h0);
    chk("arst.running", 32'(running), 32'h0);
    chk("arst.done",    32'(done),    32'h0);
    step(2);
    reset = 1'b1;
    s = cyc;
    expect_at(s + 1, "ar_reload", 16'h0042, 1'b0, 1'b0);
    expect_at(s + 4, "ar_idle",   16'h0042, 1'b0, 1'b0);
    step(5);

`ifdef LAP_CAPTURE_EN
    begin
      exp_t e;
      mode = 2'b00;
      c = cyc;
      expect_at(c + 1, "lap_clr", 16'h0000, 1'b0, 1'b0);
      pulse_clr();
      step(1);
      s = cyc;
      expect_at(s + 29, "lap_at7", 16'h0007, 1'b1, 1'b0);
      expect_at(s + 30, "lap_run", 16'h0007, 1'b1, 1'b0);
      expect_at(s + 33, "lap_cont", 16'h0008, 1'b1, 1'b0);
      e.is_lap = 1'b1; e.cnt = '0; e.run = 1'b0; e.dn = 1'b0;
      e.cyc = s + 30; e.lv = 16'h0007; e.lvld = 1'b1;
      sb.push_back(e); sb_tag.push_back("lap_cap");
      e.cyc = s + 31;
      sb.push_back(e); sb_tag.push_back("lap_hold");
      e.cyc = s + 32; e.lvld = 1'b0;
      sb.push_back(e); sb_tag.push_back("lap_off");
      pulse_ss();
      step(28);
      lap = 1'b1;
      step(1);
      lap = 1'b0;
      step(1);
      lap = 1'b1;
      step(1);
      lap = 1'b0;
      step(4);
    end
`endif

    step(2);
    while (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: expected sample at cycle %0d was never compared, got none", sb_tag[0], sb[0].cyc);
      void'(sb.pop_front());
      void'(sb_tag.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_timer_core.md
BCD_TIMER_CORE -- requirements
Module: bcd_timer_core

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits counted (1..8).
REQ-002 SHALL have parameter TICK_DIV, default 1000000: clk cycles per count step (>=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_stop  input  1  level; rising edge toggles run/pause.
REQ-006 SHALL have port clear  input  1  level; rising edge returns the block to IDLE.
REQ-007 SHALL have port mode  input  2  00 up-from-0, 01 up-from-preset, 10 down-from-all-9s, 11 down-from-preset.
REQ-008 SHALL have port preset  input  4*DIGITS  BCD start value, digit 0 in bits [3:0].
REQ-009 SHALL have port count  output  4*DIGITS  current BCD value.
REQ-010 SHALL have port running  output  1  high only in RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse on entry to DONE.
REQ-012 SHALL have ports lap  input  1, lap_value  output  4*DIGITS, lap_valid  output  1, present only with LAP_CAPTURE_EN.

Function
REQ-013 SHALL detect rising edges of start_stop, clear and lap with one registered sample each; an edge acts in the cycle after the input rises.
REQ-014 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-015 IDLE SHALL load count every cycle with the start value of the current mode: 00 -> 0, 01 -> preset, 10 -> all digits 9, 11 -> preset.
REQ-016 Loaded preset digits above 9 SHALL be clamped to 9.
REQ-017 start_stop edge SHALL move IDLE->RUN, RUN->PAUSE, PAUSE->RUN; it SHALL be ignored in DONE.
REQ-018 Mode SHALL be latched on IDLE->RUN; mode changes in RUN/PAUSE/DONE SHALL have no effect until IDLE.
REQ-019 clear edge SHALL move any state to IDLE and takes priority over a same-cycle start_stop edge.
REQ-020 Prescaler SHALL count 0..TICK_DIV-1 in RUN only, zeroed on IDLE->RUN, held (not zeroed) in PAUSE; tick SHALL fire in the cycle it equals TICK_DIV-1, then wrap to 0.
REQ-021 On tick, up modes SHALL BCD-increment count with carry across all digits; down modes SHALL BCD-decrement with borrow.
REQ-022 Terminal value SHALL be all-9s for up modes and 0 for down modes; the tick producing it SHALL move RUN->DONE in the same cycle, count holding the terminal value.
REQ-023 IDLE->RUN with start value already terminal SHALL go directly to DONE and pulse done.
REQ-024 running SHALL equal (state==RUN); done SHALL be high exactly one cycle per DONE entry.
REQ-025 count SHALL never hold a non-BCD digit.

Reset
REQ-026 Asserting reset SHALL immediately force state IDLE, count 0, prescaler 0, running 0, done 0, edge registers 0, lap_value 0, lap_valid 0.
REQ-027 After reset release IDLE SHALL load the mode start value on the first clk edge.
REQ-028 Reset mid-RUN SHALL abandon the run; no done pulse is produced.

Configuration
REQ-029 With LAP_CAPTURE_EN defined, a lap edge in RUN with lap_valid=0 SHALL copy count into lap_value and set lap_valid; a lap edge in RUN or PAUSE with lap_valid=1 SHALL clear lap_valid; clear edge SHALL clear lap_valid; counting SHALL never be affected.
REQ-030 Without LAP_CAPTURE_EN, lap, lap_value, lap_valid and their logic SHALL be absent; all other behaviour identical.

Verification (DIGITS=4, TICK_DIV=4)
REQ-031 mode=00, start edge, 40 cycles -> count 0x0010, running=1, ticks every 4 cycles.
REQ-032 mode=01, preset=0x0199, start, one tick -> count 0x0200 (multi-digit carry).
REQ-033 mode=11, preset=0x0002, start -> 0x0001, 0x0000, done pulse 1 cycle, running=0; further start edges ignored.
REQ-034 Run 6 cycles, pause 20 cycles, resume -> next tick 2 cycles after resume, count unchanged during pause.
REQ-035 clear and start_stop edges same cycle in RUN -> IDLE, count reloads start value; reset low mid-RUN -> count 0 asynchronously.
REQ-036 LAP_CAPTURE_EN: lap edge at count 0x0007 -> lap_value 0x0007, lap_valid=1 while count continues; second lap edge -> lap_valid=0.
